mux_pipe_n_to_1: RTL and testbench
==================================

MUX_PIPE_N_TO_1 -- requirements
Module: mux_pipe_n_to_1

Interface
REQ-001 Parameter SIZE, default 32, data width of each input channel and of the output.
REQ-002 Parameter SEL_BITS, default 4, select width; channel count N = 2**SEL_BITS; legal range 1..6.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port in_data  input  N*SIZE  flattened channels; channel k occupies bits [k*SIZE +: SIZE].
REQ-006 Port in_sel  input  SEL_BITS  channel index, used in direct mode.
REQ-007 Port in_mask  input  N  channel request bits, used in priority mode.
REQ-008 Port in_mode  input  1  0 = direct select, 1 = priority select.
REQ-009 Port in_valid  input  1  input beat present.
REQ-010 Port in_ready  output  1  block accepts a beat this cycle.
REQ-011 Port out_data  output  SIZE  selected channel data.
REQ-012 Port out_sel  output  SEL_BITS  index of the channel actually selected.
REQ-013 Port out_hit  output  1  1 = a channel was selected; 0 = priority mode with empty mask.
REQ-014 Port out_valid  output  1  output beat present.
REQ-015 Port out_ready  input  1  downstream accepts the output beat.

Function
REQ-016 Structure: SEL_BITS registered 2:1 tree levels; level L (L = 0 first) resolves select bit L.
REQ-017 Each level registers its data, the remaining select bits, out_sel, out_hit and a valid bit.
REQ-018 Latency: an accepted beat appears on out_* exactly SEL_BITS cycles after acceptance when no stall occurs.
REQ-019 Global advance enable: adv = !out_valid | out_ready; all stages shift only when adv = 1.
REQ-020 in_ready = adv, combinational; a beat is accepted when in_valid & in_ready.
REQ-021 When adv = 0, every stage, including out_*, holds its value unchanged.
REQ-022 Bubbles are not collapsed; an invalid stage shifts like a valid one.
REQ-023 Direct mode: the effective index is in_sel and out_hit = 1.
REQ-024 Priority mode: the effective index is the lowest set bit of in_mask and out_hit = 1.
REQ-025 Priority mode, in_mask = 0: out_data = 0, out_sel = 0, out_hit = 0; the beat is still delivered with out_valid = 1.
REQ-026 Effective index and out_hit are resolved at the acceptance cycle; later changes to in_* do not affect accepted beats.
REQ-027 out_data equals in_data channel [effective index] as captured at acceptance, bit-exact, with no width change.
REQ-028 Simultaneous accept and output consume in one cycle: both take effect, and throughput is one beat per cycle.
REQ-029 out_valid = 1 with out_ready = 0: out_data, out_sel and out_hit remain stable until the handshake completes.

Reset
REQ-030 While rst_n = 0 at a clock edge, all stage valid bits clear, out_valid = 0, out_data = 0, out_sel = 0 and out_hit = 0.
REQ-031 Reset asserted mid-flight discards all in-flight beats; none appear after reset.
REQ-032 in_ready = 1 during and immediately after reset, because out_valid = 0.
REQ-033 The first beat accepted after rst_n rises emerges SEL_BITS cycles later.

Verification
REQ-034 SEL_BITS = 4, direct mode, channel k = 32'hA000_0000 + k, in_sel = 9, out_ready = 1 -> after 4 cycles out_data = 32'hA000_0009, out_sel = 9, out_hit = 1.
REQ-035 Priority mode, in_mask = 16'h0140 -> out_sel = 6 and out_data = channel 6. in_mask = 0 -> out_hit = 0, out_data = 0, out_valid = 1.
REQ-036 Back-to-back stream of in_sel 0..15, out_ready = 1 -> 16 consecutive outputs in order, one per cycle, with in_ready always 1.
REQ-037 out_ready = 0 for 5 cycles with the pipe full -> in_ready = 0, out_* held stable, no beat lost or duplicated after release.
REQ-038 rst_n = 0 for 1 cycle with 3 beats in flight -> out_valid = 0 next cycle, and none of the 3 beats ever appears.
REQ-039 Random sweep, SEL_BITS in {1, 4, 6} and SIZE in {1, 32}, random valid/ready/mode -> scoreboard matches the reference model for every beat.

Source files
------------

// File: rtl/mux_pipe_n_to_1.sv
// Pipelined N:1 channel mux with direct or lowest-set-bit priority select.
// One registered 2:1 level per select bit, with a single valid/ready stall.
module mux_pipe_n_to_1 #(
  parameter int SIZE     = 32,
  parameter int SEL_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(2**SEL_BITS)*SIZE-1:0] in_data,
  input  logic [SEL_BITS-1:0]           in_sel,
  input  logic [(2**SEL_BITS)-1:0]      in_mask,
  input  logic                          in_mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [SIZE-1:0]               out_data,
  output logic [SEL_BITS-1:0]           out_sel,
  output logic                          out_hit,
  output logic                          out_valid,
  input  logic                          out_ready
);
  localparam int N = 2**SEL_BITS;

  logic                adv, acc;
  logic [SEL_BITS-1:0] eff_sel;
  logic                eff_hit;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign acc      = in_valid & adv;

  // Descending scan so the lowest set mask bit wins.
  always_comb begin
    eff_sel = '0;
    eff_hit = 1'b1;
    if (in_mode) begin
      eff_hit = 1'b0;
      for (int k = N-1; k >= 0; k--) begin
        if (in_mask[k]) begin
          eff_sel = SEL_BITS'(k);
          eff_hit = 1'b1;
        end
      end
    end else begin
      eff_sel = in_sel;
    end
  end

  for (genvar l = 0; l < SEL_BITS; l++) begin : g_stg
    localparam int NI = N >> l;
    localparam int NO = NI / 2;

    logic [NI*SIZE-1:0]  din;
    logic [SEL_BITS-1:0] sin;
    logic                hin, vin;
    logic [NO*SIZE-1:0]  data_d, data_q;
    logic [SEL_BITS-1:0] sel_q;
    logic                hit_q, vld_q;

    if (l == 0) begin : g_head
      // A miss zeroes all channels so the tree naturally yields 0 on channel 0.
      assign din = eff_hit ? in_data : '0;
      assign sin = eff_sel;
      assign hin = eff_hit;
      assign vin = acc;
    end else begin : g_body
      assign din = g_stg[l-1].data_q;
      assign sin = g_stg[l-1].sel_q;
      assign hin = g_stg[l-1].hit_q;
      assign vin = g_stg[l-1].vld_q;
    end

    always_comb begin
      data_d = '0;
      for (int j = 0; j < NO; j++)
        data_d[j*SIZE +: SIZE] = sin[l] ? din[(2*j+1)*SIZE +: SIZE] : din[(2*j)*SIZE +: SIZE];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q <= '0;
        sel_q  <= '0;
        hit_q  <= 1'b0;
        vld_q  <= 1'b0;
      end else if (adv) begin
        data_q <= data_d;
        sel_q  <= sin;
        hit_q  <= hin;
        vld_q  <= vin;
      end
    end
  end

  assign out_data  = g_stg[SEL_BITS-1].data_q;
  assign out_sel   = g_stg[SEL_BITS-1].sel_q;
  assign out_hit   = g_stg[SEL_BITS-1].hit_q;
  assign out_valid = g_stg[SEL_BITS-1].vld_q;

endmodule

// File: tb/tb_mux_pipe_n_to_1.sv
// Directed vector table plus hand-written stall/reset/stream sequences and a
// random sweep scored against an independent reference model.
module tb_mux_pipe_n_to_1;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] in_data;
  logic [3:0]   in_sel;
  logic [15:0]  in_mask;
  logic         in_mode, in_valid, in_ready;
  logic [31:0]  out_data;
  logic [3:0]   out_sel;
  logic         out_hit, out_valid, out_ready;

  logic [1:0]   s_in_data, s_in_mask;
  logic [0:0]   s_in_sel, s_out_data, s_out_sel;
  logic         s_in_mode, s_in_valid, s_in_ready, s_out_hit, s_out_valid, s_out_ready;

  mux_pipe_n_to_1 #(.SIZE(32), .SEL_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_mask(in_mask),
    .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_hit(out_hit), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_pipe_n_to_1 #(.SIZE(1), .SEL_BITS(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_sel(s_in_sel), .in_mask(s_in_mask),
    .in_mode(s_in_mode), .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
    .out_sel(s_out_sel), .out_hit(s_out_hit), .out_valid(s_out_valid), .out_ready(s_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] mask;
    logic [31:0] exp_data;
    logic [3:0]  exp_sel;
    logic        exp_hit;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        h;
  } exp_t;

  int           n_chk = 0;
  int           n_miss = 0;
  logic         mon_en = 1'b0;
  exp_t         sbq[$];
  logic [511:0] base_data;
  vec_t         vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t pick(input logic [511:0] d, input logic m, input logic [3:0] s,
                                input logic [15:0] mk);
    exp_t e;
    e.d = '0; e.s = '0; e.h = 1'b1;
    if (!m) e.s = s;
    else begin
      e.h = 1'b0;
      for (int k = 0; k < 16; k++)
        if (mk[k] && !e.h) begin
          e.s = 4'(k);
          e.h = 1'b1;
        end
    end
    if (e.h) e.d = d[e.s*32 +: 32];
    return e;
  endfunction

  // Scoreboard: handshakes are sampled mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) sbq.delete();
      else begin
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_miss++;
            $display("FAIL sb_unexpected: got beat sel=%0d data=%0h, required none", out_sel, out_data);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_data", 64'(out_data), 64'(e.d));
            chk("sb_sel", 64'(out_sel), 64'(e.s));
            chk("sb_hit", 64'(out_hit), 64'(e.h));
          end
        end
        if (in_valid && in_ready) sbq.push_back(pick(in_data, in_mode, in_sel, in_mask));
      end
    end
  end

  // One beat, then scrambled inputs; checks SEL_BITS-cycle latency and drain.
  task automatic apply_vec(input vec_t v);
    in_data = base_data; in_mode = v.mode; in_sel = v.sel; in_mask = v.mask;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("vec_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; in_data = ~base_data; in_sel = ~v.sel; in_mask = ~v.mask; in_mode = ~v.mode;
    tick();
    tick();
    chk("vec_early_valid", 64'(out_valid), 64'd0);
    tick();
    chk("vec_valid", 64'(out_valid), 64'd1);
    chk("vec_data", 64'(out_data), 64'(v.exp_data));
    chk("vec_sel", 64'(out_sel), 64'(v.exp_sel));
    chk("vec_hit", 64'(out_hit), 64'(v.exp_hit));
    tick();
    chk("vec_drained", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hold_d;
    logic [3:0]  hold_s;

    for (int k = 0; k < 16; k++) base_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    vt[0] = '{1'b0, 4'd9,  16'h0000, 32'hA000_0009, 4'd9,  1'b1};
    vt[1] = '{1'b0, 4'd0,  16'hFFFF, 32'hA000_0000, 4'd0,  1'b1};
    vt[2] = '{1'b0, 4'd15, 16'h0001, 32'hA000_000F, 4'd15, 1'b1};
    vt[3] = '{1'b1, 4'd0,  16'h0140, 32'hA000_0006, 4'd6,  1'b1};
    vt[4] = '{1'b1, 4'd9,  16'h0000, 32'h0000_0000, 4'd0,  1'b0};
    vt[5] = '{1'b1, 4'd0,  16'h8000, 32'hA000_000F, 4'd15, 1'b1};
    vt[6] = '{1'b1, 4'd3,  16'hFFFF, 32'hA000_0000, 4'd0,  1'b1};
    vt[7] = '{1'b1, 4'd5,  16'h0400, 32'hA000_000A, 4'd10, 1'b1};
    vt[8] = '{1'b0, 4'd6,  16'h0000, 32'hA000_0006, 4'd6,  1'b1};

    rst_n = 1'b0; in_data = base_data; in_sel = '0; in_mask = '0; in_mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    s_in_data = '0; s_in_sel = '0; s_in_mask = '0; s_in_mode = 1'b0; s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_sel", 64'(out_sel), 64'd0);
    chk("rst_hit", 64'(out_hit), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_s_valid", 64'(s_out_valid), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply_vec(vt[i]);

    // Single-level, 1-bit instance: latency of one cycle.
    s_in_data = 2'b10; s_in_sel = 1'b1; s_in_mode = 1'b0; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0; s_in_data = 2'b01;
    chk("s_dir_valid", 64'(s_out_valid), 64'd1);
    chk("s_dir_data", 64'(s_out_data), 64'd1);
    chk("s_dir_sel", 64'(s_out_sel), 64'd1);
    s_in_mode = 1'b1; s_in_mask = 2'b10; s_in_data = 2'b01; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    chk("s_pri_data", 64'(s_out_data), 64'd0);
    chk("s_pri_sel", 64'(s_out_sel), 64'd1);
    chk("s_pri_hit", 64'(s_out_hit), 64'd1);
    s_in_mask = 2'b00; s_in_data = 2'b11; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    chk("s_miss_valid", 64'(s_out_valid), 64'd1);
    chk("s_miss_hit", 64'(s_out_hit), 64'd0);
    chk("s_miss_data", 64'(s_out_data), 64'd0);
    tick();
    chk("s_drained", 64'(s_out_valid), 64'd0);

    // Back-to-back stream of all 16 channels.
    mon_en = 1'b1;
    in_data = base_data; in_mode = 1'b0; in_mask = '0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (cyc < 16);
      in_sel = 4'(cyc);
      #1;
      chk("stream_ready", 64'(in_ready), 64'd1);
      tick();
      if (cyc >= 3 && cyc < 19) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_sel", 64'(out_sel), 64'(cyc - 3));
      end
    end
    in_valid = 1'b0;
    tick();

    // Full pipe, downstream stalls five cycles.
    for (int i = 0; i < 4; i++) begin
      in_sel = 4'(i); in_valid = 1'b1;
      tick();
    end
    chk("stall_full", 64'(out_valid), 64'd1);
    out_ready = 1'b0; in_sel = 4'd4;
    #1;
    hold_d = out_data; hold_s = out_sel;
    chk("stall_head", 64'(hold_s), 64'd0);
    for (int c = 0; c < 5; c++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(hold_d));
      chk("stall_sel", 64'(out_sel), 64'(hold_s));
    end
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      in_sel = 4'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("stall_drain", 64'(sbq.size()), 64'd0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      in_sel = 4'(10 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    apply_vec(vt[7]);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrst_none", 64'(out_valid), 64'd0);
    end

    // Random sweep.
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 16; k++) in_data[k*32 +: 32] = $urandom;
      in_valid = ($urandom_range(0, 2) != 0);
      in_mode = $urandom_range(0, 1) == 1;
      in_sel = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: in_mask = '0;
        1: in_mask = 16'(1) << $urandom_range(0, 15);
        default: in_mask = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("rand_drain", 64'(sbq.size()), 64'd0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
    $finish;
  end
endmodule
